// File: rtl/bs_ntrfs_fifo.sv
// Host-side bus interface: a TX FIFO (host -> bus controller) and an RX FIFO
// (bus controller -> host), both first-word-fall-through, with sticky error flags.

module bs_ntrfs_fifo_ring #(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned depth   = 8,
    parameter int unsigned cnt_w   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [pckg_sz-1:0] wdata,
    input  logic               rd,
    output logic [pckg_sz-1:0] head_c,
    output logic [cnt_w-1:0]   cnt,
    output logic               full_c,
    output logic               ovf_c,
    output logic               udf_c
);

    localparam int unsigned aw = (depth > 1) ? $clog2(depth) : 1;

    logic [aw-1:0]      wptr_q, wptr_d;
    logic [aw-1:0]      rptr_q, rptr_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic [pckg_sz-1:0] mem_q [depth];
    logic [pckg_sz-1:0] mem_d [depth];
    logic               empty_c;
    logic               wr_ok_c;
    logic               rd_ok_c;

    // A read at full frees the slot the simultaneous write lands in.
    always_comb begin
        empty_c = (cnt_q == '0);
        full_c  = (cnt_q == cnt_w'(depth));
        rd_ok_c = rd && !empty_c;
        wr_ok_c = wr && (!full_c || rd_ok_c);
        ovf_c   = wr && !wr_ok_c;
        udf_c   = rd && empty_c;
        head_c  = empty_c ? '0 : mem_q[rptr_q];

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;

        if (wr_ok_c) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + aw'(1);
        end
        if (rd_ok_c) begin
            rptr_d = rptr_q + aw'(1);
        end

        unique case ({wr_ok_c, rd_ok_c})
            2'b10:   cnt_d = cnt_q + cnt_w'(1);
            2'b01:   cnt_d = cnt_q - cnt_w'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

module bs_ntrfs_fifo #(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned depth   = 8,
    parameter int unsigned cnt_w   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rd_en,
    output logic [pckg_sz-1:0] rd_data,
    output logic               rx_vld,
    output logic [cnt_w-1:0]   tx_cnt,
    output logic [cnt_w-1:0]   rx_cnt,
    output logic               tx_full,
    output logic               rx_full,
    output logic [3:0]         err,
    input  logic               clr_err
);

    logic       tx_ovf_c, tx_udf_c, rx_ovf_c, rx_udf_c;
    logic [3:0] new_err_c;
    logic [3:0] err_q, err_d;

    bs_ntrfs_fifo_ring #(
        .pckg_sz (pckg_sz),
        .depth   (depth),
        .cnt_w   (cnt_w)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr_en),
        .wdata  (wr_data),
        .rd     (pop),
        .head_c (D_pop),
        .cnt    (tx_cnt),
        .full_c (tx_full),
        .ovf_c  (tx_ovf_c),
        .udf_c  (tx_udf_c)
    );

    // Packets from the bus are stored untouched; addressing is the controller's job.
    bs_ntrfs_fifo_ring #(
        .pckg_sz (pckg_sz),
        .depth   (depth),
        .cnt_w   (cnt_w)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .wr     (push),
        .wdata  (D_push),
        .rd     (rd_en),
        .head_c (rd_data),
        .cnt    (rx_cnt),
        .full_c (rx_full),
        .ovf_c  (rx_ovf_c),
        .udf_c  (rx_udf_c)
    );

    // A clear in the same cycle as a new error keeps only the new error.
    always_comb begin
        new_err_c = {rx_udf_c, rx_ovf_c, tx_udf_c, tx_ovf_c};
        err_d     = clr_err ? new_err_c : (err_q | new_err_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err    = err_q;
    assign pndng  = (tx_cnt != '0);
    assign rx_vld = (rx_cnt != '0);

endmodule

// File: tb/tb_bs_ntrfs_fifo.sv
// Directed bench for bs_ntrfs_fifo: vector table plus hand-written reset and wrap sequences.

module tb_bs_ntrfs_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rx_vld;
    logic [3:0]  tx_cnt;
    logic [3:0]  rx_cnt;
    logic        tx_full;
    logic        rx_full;
    logic [3:0]  err;
    logic        clr_err;

    int n_tests = 0;
    int n_fail  = 0;

    bs_ntrfs_fifo #(
        .pckg_sz (16),
        .depth   (8),
        .cnt_w   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .pndng   (pndng),
        .D_pop   (D_pop),
        .pop     (pop),
        .push    (push),
        .D_push  (D_push),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rx_vld  (rx_vld),
        .tx_cnt  (tx_cnt),
        .rx_cnt  (rx_cnt),
        .tx_full (tx_full),
        .rx_full (rx_full),
        .err     (err),
        .clr_err (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_data;
        logic        pop;
        logic        push;
        logic [15:0] d_push;
        logic        rd_en;
        logic        clr_err;
        logic [3:0]  e_tc;
        logic [15:0] e_dpop;
        logic [3:0]  e_rc;
        logic [15:0] e_rd;
        logic [3:0]  e_err;
    } vec_t;

    vec_t vecs[$];

    logic [47:0] act;
    assign act = {pndng, D_pop, tx_cnt, tx_full, rx_vld, rd_data, rx_cnt, rx_full, err};

    function automatic vec_t mk(input logic w, input logic [15:0] wd, input logic p,
                                input logic pu, input logic [15:0] dp, input logic r,
                                input logic c, input logic [3:0] tc, input logic [15:0] dpop,
                                input logic [3:0] rc, input logic [15:0] rdd, input logic [3:0] e);
        vec_t v;
        v.wr_en = w;  v.wr_data = wd; v.pop = p;
        v.push = pu;  v.d_push = dp;  v.rd_en = r; v.clr_err = c;
        v.e_tc = tc;  v.e_dpop = dpop; v.e_rc = rc; v.e_rd = rdd; v.e_err = e;
        return v;
    endfunction

    // Flags follow directly from the expected occupancies (depth 8).
    function automatic logic [47:0] expv(input logic [3:0] tc, input logic [15:0] dpop,
                                         input logic [3:0] rc, input logic [15:0] rdd,
                                         input logic [3:0] e);
        return {(tc != 4'd0), dpop, tc, (tc == 4'd8), (rc != 4'd0), rdd, rc, (rc == 4'd8), e};
    endfunction

    task automatic drive(input logic w, input logic [15:0] wd, input logic p, input logic pu,
                         input logic [15:0] dp, input logic r, input logic c);
        @(negedge clk);
        wr_en = w; wr_data = wd; pop = p; push = pu; D_push = dp; rd_en = r; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; pop = 1'b0; push = 1'b0;
        D_push = '0; rd_en = 1'b0; clr_err = 1'b0;

        // Single packet, TX fill/overflow, simultaneous ops at full.
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 4'd0, 16'h0, 4'b0000));
        vecs.push_back(mk(1, 16'hA5C3, 0, 0, 16'h0, 0, 0, 4'd1, 16'hA5C3, 4'd0, 16'h0, 4'b0000));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 4'd0, 16'h0, 4'b0000));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 16'(i), 0, 0, 16'h0, 0, 0, 4'(i), 16'h0001, 4'd0, 16'h0, 4'b0000));
        vecs.push_back(mk(1, 16'h0009, 0, 0, 16'h0, 0, 0, 4'd8, 16'h0001, 4'd0, 16'h0, 4'b0001));
        vecs.push_back(mk(1, 16'h00FF, 1, 0, 16'h0, 0, 0, 4'd8, 16'h0002, 4'd0, 16'h0, 4'b0001));
        for (int k = 1; k <= 7; k++)
            vecs.push_back(mk(0, 16'h0, 1, 0, 16'h0, 0, 0, 4'(8 - k),
                              (k <= 6) ? 16'(k + 2) : 16'h00FF, 4'd0, 16'h0, 4'b0001));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 4'd0, 16'h0, 4'b0001));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0, 0, 1, 4'd0, 16'h0000, 4'd0, 16'h0, 4'b0000));
        // TX underflow, then write+pop on empty together with a clear.
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 4'd0, 16'h0, 4'b0010));
        vecs.push_back(mk(1, 16'h0042, 1, 0, 16'h0, 0, 1, 4'd1, 16'h0042, 4'd0, 16'h0, 4'b0010));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0, 0, 0, 4'd0, 16'h0000, 4'd0, 16'h0, 4'b0010));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0, 0, 1, 4'd0, 16'h0000, 4'd0, 16'h0, 4'b0000));
        // RX path and underflow.
        vecs.push_back(mk(0, 16'h0, 0, 1, 16'hFF10, 0, 0, 4'd0, 16'h0, 4'd1, 16'hFF10, 4'b0000));
        vecs.push_back(mk(0, 16'h0, 0, 1, 16'h0220, 0, 0, 4'd0, 16'h0, 4'd2, 16'hFF10, 4'b0000));
        vecs.push_back(mk(0, 16'h0, 0, 0, 16'h0000, 1, 0, 4'd0, 16'h0, 4'd1, 16'h0220, 4'b0000));
        vecs.push_back(mk(0, 16'h0, 0, 0, 16'h0000, 1, 0, 4'd0, 16'h0, 4'd0, 16'h0000, 4'b0000));
        vecs.push_back(mk(0, 16'h0, 0, 0, 16'h0000, 1, 0, 4'd0, 16'h0, 4'd0, 16'h0000, 4'b1000));
        vecs.push_back(mk(0, 16'h0, 0, 0, 16'h0000, 0, 1, 4'd0, 16'h0, 4'd0, 16'h0000, 4'b0000));
        // RX fill, overflow, push+read at full.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 16'h0, 0, 1, 16'h0100 + 16'(i), 0, 0, 4'd0, 16'h0, 4'(i),
                              16'h0101, 4'b0000));
        vecs.push_back(mk(0, 16'h0, 0, 1, 16'h01FF, 0, 0, 4'd0, 16'h0, 4'd8, 16'h0101, 4'b0100));
        vecs.push_back(mk(0, 16'h0, 0, 1, 16'h0AAA, 1, 0, 4'd0, 16'h0, 4'd8, 16'h0102, 4'b0100));
        vecs.push_back(mk(0, 16'h0, 0, 0, 16'h0000, 0, 1, 4'd0, 16'h0, 4'd8, 16'h0102, 4'b0000));

        #1;
        check("reset_state", act, 48'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].pop, vecs[i].push,
                  vecs[i].d_push, vecs[i].rd_en, vecs[i].clr_err);
            check($sformatf("vec[%0d]", i), act,
                  expv(vecs[i].e_tc, vecs[i].e_dpop, vecs[i].e_rc, vecs[i].e_rd, vecs[i].e_err));
        end

        // Reset discards the full RX FIFO.
        @(negedge clk);
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_clears_rx", act, 48'h0);
        @(negedge clk);
        rst = 1'b1;

        // Build tx_cnt=5, rx_cnt=3, then reset between edges.
        for (int i = 0; i < 5; i++)
            drive(1'b1, 16'h0010 + 16'(i), 1'b0, (i < 3), 16'h0020 + 16'(i), 1'b0, 1'b0);
        check("prefill_5_3", act, expv(4'd5, 16'h0010, 4'd3, 16'h0020, 4'b0000));
        @(negedge clk);
        wr_en = 1'b0; push = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_immediate", act, 48'h0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", act, 48'h0);
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_data = 16'h1234; push = 1'b1; D_push = 16'h5678;
        @(posedge clk);
        #1;
        check("first_edge_after_reset", act, expv(4'd1, 16'h1234, 4'd1, 16'h5678, 4'b0000));
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check("drain_after_reset", act, 48'h0);

        // Pointer wrap: 20 write/pop pairs.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            check($sformatf("wrap_wr[%0d]", i), act,
                  expv(4'd1, 16'h3000 + 16'(i), 4'd0, 16'h0, 4'b0000));
            drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            check($sformatf("wrap_pop[%0d]", i), act, 48'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
